// File: rtl/i2c_arb_pkg.sv
// Shared types for the two-port I2C master arbiter: FSM states, default widths, command layout.
package i2c_arb_pkg;

  localparam int ARB_ADDR_W = 7;
  localparam int ARB_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Default-width command record; the top re-declares it with its own parameter widths.
  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic                  rw;
    logic [ARB_DATA_W-1:0] wdata;
  } arb_cmd_t;

endpackage

// File: rtl/i2c_rr_picker.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the port not served last.
module i2c_rr_picker (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_pick
);

  always_comb begin
    o_pick = i_req;
    if (&i_req) o_pick = i_last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C byte master between two requesters (round-robin, latched command).
// Optional WAIT watchdog with master abort: define I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int ADDR_W         = ARB_ADDR_W,
  parameter int DATA_W         = ARB_DATA_W,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [1:0]        i_req,
  input  logic [ADDR_W-1:0] i_req_addr0,
  input  logic [ADDR_W-1:0] i_req_addr1,
  input  logic [1:0]        i_req_rw,
  input  logic [DATA_W-1:0] i_req_wdata0,
  input  logic [DATA_W-1:0] i_req_wdata1,
  output logic [1:0]        o_gnt,
  output logic [1:0]        o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err,
  output logic              o_m_start,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic              o_m_rw,
  output logic [DATA_W-1:0] o_m_wdata,
  input  logic              i_m_busy,
  input  logic              i_m_done,
  input  logic              i_m_nack,
  input  logic [DATA_W-1:0] i_m_rdata,
  output logic              o_m_abort
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  arb_state_t        r_state, w_state_nxt;
  cmd_t              r_cmd, w_cmd_sel;
  logic [1:0]        r_gnt, w_pick;
  logic              r_last;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              w_start, w_abort, w_tmo;

  i2c_rr_picker u_picker (
    .i_req  (i_req),
    .i_last (r_last),
    .o_pick (w_pick)
  );

  always_comb begin
    w_cmd_sel.addr  = i_req_addr0;
    w_cmd_sel.rw    = i_req_rw[0];
    w_cmd_sel.wdata = i_req_wdata0;
    if (w_pick[1]) begin
      w_cmd_sel.addr  = i_req_addr1;
      w_cmd_sel.rw    = i_req_rw[1];
      w_cmd_sel.wdata = i_req_wdata1;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  // Cleared while in ISSUE so it starts at zero on the first WAIT cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                 r_tmo_cnt <= '0;
    else if (r_state == ST_ISSUE) r_tmo_cnt <= '0;
    else if (r_state == ST_WAIT)  r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_tmo = (r_state == ST_WAIT) && !i_m_done &&
                 (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign w_tmo        = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE:  if (|i_req) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (!i_m_busy) begin
        w_start     = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_m_done) begin
          w_state_nxt = ST_RESP;
        end else if (w_tmo) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_last  <= 1'b1;
      r_cmd   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: if (|i_req) begin
          r_gnt <= w_pick;
          r_cmd <= w_cmd_sel;
        end
        ST_WAIT: begin
          if (i_m_done) begin
            r_rdata <= i_m_rdata;
            r_err   <= i_m_nack;
            r_last  <= r_gnt[1];
          end else if (w_tmo) begin
            r_err  <= 1'b1;
            r_last <= r_gnt[1];
          end
        end
        ST_RESP: r_gnt <= '0;
        default: ;
      endcase
    end
  end

  // Grant stays up through RESP so done and gnt coincide for the requester.
  assign o_done    = (r_state == ST_RESP) ? r_gnt : 2'b00;
  assign o_gnt     = r_gnt;
  assign o_rdata   = r_rdata;
  assign o_err     = r_err;
  assign o_m_start = w_start;
  assign o_m_abort = w_abort;
  assign o_m_addr  = r_cmd.addr;
  assign o_m_rw    = r_cmd.rw;
  assign o_m_wdata = r_cmd.wdata;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed table-driven bench for i2c_bus_arbiter plus busy/reset/timeout sequences.
module tb_i2c_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = '0;
  logic [6:0] req_addr0 = '0, req_addr1 = '0;
  logic [1:0] req_rw = '0;
  logic [7:0] req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0] gnt, done;
  logic [7:0] rdata;
  logic       err, m_start, m_rw, m_abort;
  logic [6:0] m_addr;
  logic [7:0] m_wdata;
  logic       m_busy = 1'b0, m_done = 1'b0, m_nack = 1'b0;
  logic [7:0] m_rdata = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(.ADDR_W(7), .DATA_W(8), .TIMEOUT_CYCLES(20)) dut (
    .i_clk(clk), .i_reset(reset), .i_req(req),
    .i_req_addr0(req_addr0), .i_req_addr1(req_addr1), .i_req_rw(req_rw),
    .i_req_wdata0(req_wdata0), .i_req_wdata1(req_wdata1),
    .o_gnt(gnt), .o_done(done), .o_rdata(rdata), .o_err(err),
    .o_m_start(m_start), .o_m_addr(m_addr), .o_m_rw(m_rw), .o_m_wdata(m_wdata),
    .i_m_busy(m_busy), .i_m_done(m_done), .i_m_nack(m_nack), .i_m_rdata(m_rdata),
    .o_m_abort(m_abort)
  );

  typedef struct {
    logic [1:0] req;
    logic [6:0] a0, a1;
    logic [1:0] rw;
    logic [7:0] w0, w1;
    logic       nack;
    logic [7:0] mrd;
    logic [1:0] egnt;
    logic [6:0] eaddr;
    logic       erw;
    logic [7:0] ewd;
    logic [7:0] erd;
    logic       eerr;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},     32'(gnt), 0);
    chk({tag, "_done"},    32'(done), 0);
    chk({tag, "_rdata"},   32'(rdata), 0);
    chk({tag, "_err"},     32'(err), 0);
    chk({tag, "_m_start"}, 32'(m_start), 0);
    chk({tag, "_m_addr"},  32'(m_addr), 0);
    chk({tag, "_m_rw"},    32'(m_rw), 0);
    chk({tag, "_m_wdata"}, 32'(m_wdata), 0);
    chk({tag, "_m_abort"}, 32'(m_abort), 0);
  endtask

  initial begin
    // req, a0, a1, rw, w0, w1, nack, mrd | gnt, addr, rw, wdata, rdata, err
    tbl[0] = '{2'b01, 7'h20, 7'h00, 2'b00, 8'h05, 8'h00, 1'b0, 8'h00, 2'b01, 7'h20, 1'b0, 8'h05, 8'h00, 1'b0};
    tbl[1] = '{2'b01, 7'h11, 7'h00, 2'b00, 8'h99, 8'h00, 1'b1, 8'h00, 2'b01, 7'h11, 1'b0, 8'h99, 8'h00, 1'b1};
    tbl[2] = '{2'b01, 7'h12, 7'h00, 2'b00, 8'h42, 8'h00, 1'b0, 8'h5A, 2'b01, 7'h12, 1'b0, 8'h42, 8'h5A, 1'b0};
    tbl[3] = '{2'b10, 7'h00, 7'h48, 2'b10, 8'h00, 8'h3C, 1'b0, 8'hA7, 2'b10, 7'h48, 1'b1, 8'h3C, 8'hA7, 1'b0};
    tbl[4] = '{2'b11, 7'h30, 7'h31, 2'b01, 8'hAA, 8'hBB, 1'b0, 8'hC1, 2'b01, 7'h30, 1'b1, 8'hAA, 8'hC1, 1'b0};
    tbl[5] = '{2'b11, 7'h30, 7'h31, 2'b01, 8'hAA, 8'hBB, 1'b0, 8'h00, 2'b10, 7'h31, 1'b0, 8'hBB, 8'h00, 1'b0};
    tbl[6] = '{2'b11, 7'h30, 7'h31, 2'b01, 8'hAA, 8'hBB, 1'b0, 8'h7E, 2'b01, 7'h30, 1'b1, 8'hAA, 8'h7E, 1'b0};
    tbl[7] = '{2'b11, 7'h30, 7'h31, 2'b01, 8'hAA, 8'hBB, 1'b1, 8'h00, 2'b10, 7'h31, 1'b0, 8'hBB, 8'h00, 1'b1};

    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req; req_addr0 = tbl[i].a0; req_addr1 = tbl[i].a1;
      req_rw = tbl[i].rw; req_wdata0 = tbl[i].w0; req_wdata1 = tbl[i].w1;
      tick();
      chk($sformatf("v%0d_gnt", i),     32'(gnt), 32'(tbl[i].egnt));
      chk($sformatf("v%0d_start", i),   32'(m_start), 1);
      chk($sformatf("v%0d_addr", i),    32'(m_addr), 32'(tbl[i].eaddr));
      chk($sformatf("v%0d_rw", i),      32'(m_rw), 32'(tbl[i].erw));
      chk($sformatf("v%0d_wdata", i),   32'(m_wdata), 32'(tbl[i].ewd));
      tick();
      chk($sformatf("v%0d_start_lo", i), 32'(m_start), 0);
      chk($sformatf("v%0d_nodone", i),  32'(done), 0);
      m_done = 1'b1; m_nack = tbl[i].nack; m_rdata = tbl[i].mrd;
      tick();
      m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
      chk($sformatf("v%0d_done", i),    32'(done), 32'(tbl[i].egnt));
      chk($sformatf("v%0d_rdata", i),   32'(rdata), 32'(tbl[i].erd));
      chk($sformatf("v%0d_err", i),     32'(err), 32'(tbl[i].eerr));
      tick();
      chk($sformatf("v%0d_idle_done", i), 32'(done), 0);
      chk($sformatf("v%0d_idle_gnt", i),  32'(gnt), 0);
    end
    req = 2'b00;
    tick();

    // Busy master: no strobe while busy; command immune to req/data changes.
    m_busy = 1'b1;
    req = 2'b01; req_addr0 = 7'h55; req_rw = 2'b01; req_wdata0 = 8'h0F;
    tick();
    chk("busy_gnt", 32'(gnt), 32'h1);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("busy_nostart%0d", c), 32'(m_start), 0);
      req = 2'b00; req_addr0 = 7'h66; req_wdata0 = 8'hF0; req_rw = 2'b00;
      if (c < 9) tick();
    end
    m_busy = 1'b0;
    #1;
    chk("busy_start", 32'(m_start), 1);
    chk("busy_addr", 32'(m_addr), 32'h55);
    chk("busy_rw", 32'(m_rw), 1);
    chk("busy_wdata", 32'(m_wdata), 32'h0F);
    tick();
    chk("busy_start_once", 32'(m_start), 0);
    m_done = 1'b1; m_rdata = 8'h9D;
    tick();
    m_done = 1'b0; m_rdata = 8'h00;
    chk("busy_done", 32'(done), 32'h1);
    chk("busy_rdata", 32'(rdata), 32'h9D);
    tick();

    // Reset during WAIT.
    req = 2'b10; req_addr1 = 7'h2B; req_rw = 2'b10; req_wdata1 = 8'h77;
    tick();
    chk("rst_pre_start", 32'(m_start), 1);
    tick();
    chk("rst_pre_gnt", 32'(gnt), 32'h2);
    req = 2'b00;
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("rstwait");
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rst_nodone%0d", c), 32'(done), 0);
    end

    // After reset, a tie goes to port 0.
    req = 2'b11; req_addr0 = 7'h01; req_addr1 = 7'h02; req_rw = 2'b00;
    tick();
    chk("rst_tie_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    tick();
    m_done = 1'b1; m_rdata = 8'h33;
    tick();
    m_done = 1'b0;
    chk("rst_tie_done", 32'(done), 32'h1);
    tick();

`ifdef I2C_ARB_TIMEOUT_EN
    begin
      int k;
      req = 2'b10; req_addr1 = 7'h44; req_rw = 2'b00;
      tick();
      chk("tmo_start", 32'(m_start), 1);
      req = 2'b00;
      tick();
      k = 0;
      while (!m_abort && k < 100) begin
        tick();
        k++;
      end
      chk("tmo_abort_seen", 32'(m_abort), 1);
      chk("tmo_abort_cycle", 32'(k), 19);
      tick();
      chk("tmo_abort_pulse", 32'(m_abort), 0);
      chk("tmo_done", 32'(done), 32'h2);
      chk("tmo_err", 32'(err), 1);
      chk("tmo_rdata", 32'(rdata), 32'h33);
      tick();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
